// File: rtl/npu_pkg.sv
// Shared NPU constants and types: tile geometry and the result-writer FSM state encoding.
package npu_pkg;

  localparam int TILE_WORDS = 64;
  localparam int BANK_OFS_W = 5;
  localparam int K_W        = $clog2(TILE_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } wr_state_t;

endpackage

// File: rtl/wr_addr_cnt.sv
// Word index k within a tile and the tile base shared by both banks.
import npu_pkg::*;

module wr_addr_cnt #(
  parameter int ADDR_W = 10
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         inc,
  output logic [K_W-1:0]               k,
  output logic [ADDR_W-BANK_OFS_W-1:0] tile_base,
  output logic                         last
);

  logic [K_W-1:0]               k_q, k_d;
  logic [ADDR_W-BANK_OFS_W-1:0] base_q, base_d;

  assign last = (k_q == K_W'(TILE_WORDS - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    k_d    = k_q;
    base_d = base_q;
    if (inc) begin
      k_d = k_q + K_W'(1);
      // Advancing the base on word 63 is equivalent to advancing on leaving DONE:
      // no beat is accepted in between, so no address ever sees the difference.
      if (last) base_d = base_q + (ADDR_W - BANK_OFS_W)'(1);
    end
    if (clr) begin
      k_d    = '0;
      base_d = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge ck) begin
    if (!rst) begin
      k_q    <= '0;
      base_q <= '0;
    end else begin
      k_q    <= k_d;
      base_q <= base_d;
    end
  end

  assign k         = k_q;
  assign tile_base = base_q;

endmodule

// File: rtl/data_wr_ctrl.sv
// Streams 64-word result tiles into an even/odd bank pair with registered write ports.
// Optional DATA_WR_CTRL_PARITY_EN adds a registered even-parity output mem_wpar.
import npu_pkg::*;

module data_wr_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              sync_clr,
  input  logic              en,
  input  logic              mem_busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we_even,
  output logic              mem_we_odd,
  output logic [ADDR_W-1:0] mem_addr_even,
  output logic [ADDR_W-1:0] mem_addr_odd,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              tile_done
`ifdef DATA_WR_CTRL_PARITY_EN
  ,output logic             mem_wpar
`endif
);

  wr_state_t                    state_q, state_d;
  logic                         we_even_q, we_even_d;
  logic                         we_odd_q, we_odd_d;
  logic [ADDR_W-1:0]            addr_even_q, addr_even_d;
  logic [ADDR_W-1:0]            addr_odd_q, addr_odd_d;
  logic [DATA_W-1:0]            wdata_q, wdata_d;
`ifdef DATA_WR_CTRL_PARITY_EN
  logic                         wpar_q, wpar_d;
`endif

  logic [K_W-1:0]               k;
  logic [ADDR_W-BANK_OFS_W-1:0] tile_base;
  logic                         last;
  logic                         accept;
  logic [ADDR_W-1:0]            bank_addr;

  assign in_ready  = (state_q == WRITE) && en && !mem_busy && !sync_clr;
  assign accept    = in_valid && in_ready;
  assign bank_addr = {tile_base, k[K_W-1:1]};
  assign tile_done = (state_q == DONE);

  wr_addr_cnt #(
    .ADDR_W (ADDR_W)
  ) u_cnt (
    .ck        (ck),
    .rst       (rst),
    .clr       (sync_clr),
    .inc       (accept),
    .k         (k),
    .tile_base (tile_base),
    .last      (last)
  );

  always_comb begin
    state_d     = state_q;
    we_even_d   = 1'b0;
    we_odd_d    = 1'b0;
    addr_even_d = addr_even_q;
    addr_odd_d  = addr_odd_q;
    wdata_d     = wdata_q;
`ifdef DATA_WR_CTRL_PARITY_EN
    wpar_d      = wpar_q;
`endif

    unique case (state_q)
      IDLE:    if (en) state_d = WRITE;
      WRITE:   if (accept && last) state_d = DONE;
      DONE:    state_d = en ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase

    // in_data is only looked at on an accepted beat, so idle X never reaches the ports.
    if (accept) begin
      if (k[0]) begin
        we_odd_d   = 1'b1;
        addr_odd_d = bank_addr;
      end else begin
        we_even_d   = 1'b1;
        addr_even_d = bank_addr;
      end
      wdata_d = in_data;
`ifdef DATA_WR_CTRL_PARITY_EN
      wpar_d  = ^in_data;
`endif
    end

    if (sync_clr) begin
      state_d     = IDLE;
      we_even_d   = 1'b0;
      we_odd_d    = 1'b0;
      addr_even_d = '0;
      addr_odd_d  = '0;
      wdata_d     = '0;
`ifdef DATA_WR_CTRL_PARITY_EN
      wpar_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_even_q   <= 1'b0;
      we_odd_q    <= 1'b0;
      addr_even_q <= '0;
      addr_odd_q  <= '0;
      wdata_q     <= '0;
`ifdef DATA_WR_CTRL_PARITY_EN
      wpar_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_even_q   <= we_even_d;
      we_odd_q    <= we_odd_d;
      addr_even_q <= addr_even_d;
      addr_odd_q  <= addr_odd_d;
      wdata_q     <= wdata_d;
`ifdef DATA_WR_CTRL_PARITY_EN
      wpar_q      <= wpar_d;
`endif
    end
  end

  assign mem_we_even   = we_even_q;
  assign mem_we_odd    = we_odd_q;
  assign mem_addr_even = addr_even_q;
  assign mem_addr_odd  = addr_odd_q;
  assign mem_wdata     = wdata_q;
`ifdef DATA_WR_CTRL_PARITY_EN
  assign mem_wpar      = wpar_q;
`endif

endmodule

// File: tb/tb_data_wr_ctrl.sv
// Directed bench for data_wr_ctrl: reset, full tile, base wrap, sync clear, back-pressure, parity.
module tb_data_wr_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  logic              ck;
  logic              rst;
  logic              sync_clr;
  logic              en;
  logic              mem_busy;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we_even;
  logic              mem_we_odd;
  logic [ADDR_W-1:0] mem_addr_even;
  logic [ADDR_W-1:0] mem_addr_odd;
  logic [DATA_W-1:0] mem_wdata;
  logic              tile_done;
`ifdef DATA_WR_CTRL_PARITY_EN
  logic              mem_wpar;
`endif

  data_wr_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .ck            (ck),
    .rst           (rst),
    .sync_clr      (sync_clr),
    .en            (en),
    .mem_busy      (mem_busy),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mem_we_even   (mem_we_even),
    .mem_we_odd    (mem_we_odd),
    .mem_addr_even (mem_addr_even),
    .mem_addr_odd  (mem_addr_odd),
    .mem_wdata     (mem_wdata),
    .tile_done     (tile_done)
`ifdef DATA_WR_CTRL_PARITY_EN
    ,.mem_wpar     (mem_wpar)
`endif
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Bank shadow memories and event counters filled by the monitor below.
  logic [DATA_W-1:0] ev_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] od_mem [0:(1<<ADDR_W)-1];
  int ev_cnt, od_cnt, done_cnt, bad_cnt;
  logic [ADDR_W-1:0] done_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge ck) begin
    if (mem_we_even === 1'b1) begin
      ev_mem[mem_addr_even] = mem_wdata;
      ev_cnt++;
    end
    if (mem_we_odd === 1'b1) begin
      od_mem[mem_addr_odd] = mem_wdata;
      od_cnt++;
    end
    if (mem_we_even === 1'b1 && mem_we_odd === 1'b1) bad_cnt++;
    if (tile_done === 1'b1) begin
      done_cnt++;
      done_addr = mem_addr_odd;
      if (mem_we_odd !== 1'b1) bad_cnt++;
    end
  end

  task automatic clear_shadow();
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ev_mem[i] = '1;
      od_mem[i] = '1;
    end
    ev_cnt   = 0;
    od_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic wait_pos();
    @(posedge ck);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge ck);
    #1;
  endtask

  // Call only in the window just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [DATA_W-1:0] d);
    logic acc;
    int   cyc;
    in_valid = 1'b1;
    in_data  = d;
    acc      = 1'b0;
    cyc      = 0;
    while (!acc && cyc < 20) begin
      @(negedge ck);
      acc = in_ready;
      wait_pos();
      cyc++;
    end
    if (!acc) check("push_timeout", 64'(d), 64'hFFFF_FFFF);
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({in_ready, mem_we_even, mem_we_odd, mem_addr_even, mem_addr_odd, mem_wdata, tile_done});
  endfunction

  initial begin
    bad_cnt  = 0;
    clear_shadow();
    rst      = 1'b0;
    sync_clr = 1'b0;
    en       = 1'b1;
    mem_busy = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0055;

    // Reset held two cycles with en and in_valid high.
    for (int i = 0; i < 2; i++) begin
      @(negedge ck);
      check("reset_outs", all_outs(), 64'd0);
`ifdef DATA_WR_CTRL_PARITY_EN
      check("reset_wpar", 64'(mem_wpar), 64'd0);
`endif
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge ck);
    check("idle_to_write_ready", 64'(in_ready), 64'd1);
    wait_pos();

    // Single tile, data = k.
    for (int k = 0; k < 64; k++) push(16'(k));
    wait_neg();
    for (int a = 0; a < 32; a++) begin
      check("tile0_even", 64'(ev_mem[a]), 64'(2 * a));
      check("tile0_odd",  64'(od_mem[a]), 64'(2 * a + 1));
    end
    check("tile0_ev_cnt", 64'(ev_cnt), 64'd32);
    check("tile0_od_cnt", 64'(od_cnt), 64'd32);
    check("tile0_done_cnt", 64'(done_cnt), 64'd1);
    check("tile0_done_addr", 64'(done_addr), 64'd31);
    wait_pos();
    push(16'd64);
    wait_neg();
    check("tile1_word0_addr32", 64'(ev_mem[32]), 64'd64);
    wait_pos();

    // Remaining tiles up to and across the tile_base wrap.
    for (int t = 1; t < 32; t++)
      for (int k = (t == 1) ? 1 : 0; k < 64; k++) push(16'(t * 64 + k));
    push(16'hABCD);
    wait_neg();
    for (int j = 0; j < 32; j++) begin
      check("tile31_even", 64'(ev_mem[992 + j]), 64'(31 * 64 + 2 * j));
      check("tile31_odd",  64'(od_mem[992 + j]), 64'(31 * 64 + 2 * j + 1));
    end
    check("wrap_word0_addr0", 64'(ev_mem[0]), 64'hABCD);
    check("wrap_done_cnt", 64'(done_cnt), 64'd32);
    check("wrap_done_addr", 64'(done_addr), 64'd1023);
    check("no_dual_strobe", 64'(bad_cnt), 64'd0);

    // Sync clear coinciding with word 41.
    clear_shadow();
    wait_pos();
    for (int k = 1; k <= 40; k++) push(16'(16'h2000 + k));
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    sync_clr = 1'b1;
    wait_pos();
    sync_clr = 1'b0;
    in_valid = 1'b0;
    @(negedge ck);
    check("clr_outs_zero", all_outs(), 64'd0);
`ifdef DATA_WR_CTRL_PARITY_EN
    check("clr_wpar_zero", 64'(mem_wpar), 64'd0);
`endif
    wait_pos();
    push(16'h1234);
    wait_neg();
    check("clr_word40_kept", 64'(ev_mem[20]), 64'h2028);
    check("clr_word41_dropped", 64'(od_mem[20]), 64'hFFFF);
    check("clr_next_word0", 64'(ev_mem[0]), 64'h1234);
    check("clr_ev_cnt", 64'(ev_cnt), 64'd21);
    check("clr_od_cnt", 64'(od_cnt), 64'd20);
    check("clr_no_done", 64'(done_cnt), 64'd0);

    // Back-pressure over beats 5..7 of a fresh tile.
    wait_pos();
    rst = 1'b0;
    wait_pos();
    rst = 1'b1;
    clear_shadow();
    for (int k = 0; k < 5; k++) push(16'(16'h0300 + k));
    mem_busy = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0305;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      check("busy_not_ready", 64'(in_ready), 64'd0);
      if (i > 0) check("busy_no_strobe", 64'({mem_we_even, mem_we_odd}), 64'd0);
      wait_pos();
    end
    mem_busy = 1'b0;
    in_valid = 1'b0;
    for (int k = 5; k < 64; k++) push(16'(16'h0300 + k));
    wait_neg();
    check("busy_beat5_odd2", 64'(od_mem[2]), 64'h0305);
    check("busy_beat6_even3", 64'(ev_mem[3]), 64'h0306);
    check("busy_beat7_odd3", 64'(od_mem[3]), 64'h0307);
    check("busy_ev_cnt", 64'(ev_cnt), 64'd32);
    check("busy_od_cnt", 64'(od_cnt), 64'd32);
    check("busy_done_cnt", 64'(done_cnt), 64'd1);

    // Parity-sensitive data words.
    wait_pos();
    push(16'h0007);
    check("wdata_7", 64'(mem_wdata), 64'h0007);
`ifdef DATA_WR_CTRL_PARITY_EN
    check("wpar_7", 64'(mem_wpar), 64'd1);
`endif
    push(16'h0003);
    check("wdata_3", 64'(mem_wdata), 64'h0003);
`ifdef DATA_WR_CTRL_PARITY_EN
    check("wpar_3", 64'(mem_wpar), 64'd0);
`endif
    check("final_bad_cnt", 64'(bad_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_wr_ctrl.md
DATA_WR_CTRL -- requirements
Module: data_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of one result word.
REQ-002 SHALL have parameter ADDR_W, default 10: per-bank address width (ADDR_W >= 6).
REQ-003 SHALL have ports, clock and reset first: ck in 1 (single clock, rising edge); rst in 1 (reset, synchronous, active-low).
REQ-004 SHALL have input sync_clr, 1 bit: synchronous soft clear.
REQ-005 SHALL have input en, 1 bit: write enable. When low, the block pauses.
REQ-006 SHALL have input mem_busy, 1 bit: memory back-pressure.
REQ-007 SHALL have input in_valid, 1 bit, and input in_data, DATA_W bits: incoming result word.
REQ-008 SHALL have output in_ready, 1 bit: beat accepted when in_valid && in_ready.
REQ-009 SHALL have outputs mem_we_even and mem_we_odd, 1 bit each: bank write strobes.
REQ-010 SHALL have outputs mem_addr_even and mem_addr_odd, ADDR_W bits each: bank write addresses.
REQ-011 SHALL have output mem_wdata, DATA_W bits: write data shared by both banks.
REQ-012 SHALL have output tile_done, 1 bit: one-cycle pulse at the end of a tile.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE and DONE.
- IDLE -> WRITE when en = 1.
- WRITE -> DONE on acceptance of tile word 63.
- DONE -> WRITE if en = 1, else IDLE.
REQ-014 SHALL drive in_ready = (state == WRITE) && en && !mem_busy && !sync_clr.
REQ-015 SHALL write one tile as TILE_WORDS = 64 words, indexed k = 0..63.
- Word k goes to the even bank when k[0] = 0, and to the odd bank otherwise.
- Bank address = {tile_base, k[5:1]}.
- tile_base is ADDR_W-5 bits wide and is shared by both banks.
REQ-016 SHALL register writes with 1-cycle latency: a beat accepted at edge t produces mem_we_*, mem_addr_* and mem_wdata during cycle t+1.
REQ-017 SHALL assert exactly one of mem_we_even or mem_we_odd per accepted beat, and neither strobe in cycles with no accept.
REQ-018 SHALL hold mem_addr_even and mem_addr_odd at their last-written value when their bank is not written.
REQ-019 SHALL make DONE last exactly 1 cycle, with tile_done = 1 and in_ready = 0 during it.
- This cycle coincides with the mem_we_odd of word 63.
- On leaving DONE, tile_base increments by 1 modulo 2^(ADDR_W-5), i.e. it wraps to 0 after the last tile.
REQ-020 SHALL, when en is low in WRITE, hold k and tile_base and accept nothing, then resume at the same k.
REQ-021 SHALL, when mem_busy is high, accept nothing while keeping all state and k.
REQ-022 SHALL, when sync_clr = 1 at an edge, force the reset state of REQ-024 and ignore any coinciding beat. This includes the case where that beat is word 63 (no tile_done is produced).
REQ-023 SHALL leave in_data unused when not accepted; no X-propagation onto the mem_* outputs.

Reset
REQ-024 SHALL, on rst = 0 at a rising ck edge, set:
- state = IDLE, k = 0, tile_base = 0;
- in_ready = 0, mem_we_even = 0, mem_we_odd = 0;
- mem_addr_even = 0, mem_addr_odd = 0, mem_wdata = 0, tile_done = 0.
REQ-025 SHALL give rst priority over sync_clr, and sync_clr priority over all functional updates, including a reset applied mid-tile.

Configuration
REQ-026 SHALL support macro DATA_WR_CTRL_PARITY_EN.
- When defined: output mem_wpar, 1 bit, carries even parity (XOR of all bits) of mem_wdata, registered alongside it, reset value 0.
- When undefined: port mem_wpar and its logic are absent; behaviour is otherwise identical.

Structure
REQ-027 SHALL take from shared package npu_pkg:
- constant TILE_WORDS = 64;
- constant BANK_OFS_W = 5;
- enum wr_state_t {IDLE, WRITE, DONE}.
REQ-028 SHALL place the k/tile_base counter logic in one sub-module, wr_addr_cnt (inputs: inc, clr; outputs: k, tile_base, last).

Verification
REQ-029 SHALL cover reset: hold rst = 0 for 2 cycles with en = 1 and in_valid = 1 -> all outputs 0 and in_ready = 0 throughout; IDLE -> WRITE on the first edge after rst = 1.
REQ-030 SHALL cover a single tile: en = 1, 64 back-to-back beats with in_data = k ->
- even bank addresses 0..31 receive data 0,2,..,62;
- odd bank addresses 0..31 receive data 1,3,..,63;
- tile_done = 1 in the cycle of the odd write to address 31;
- the next tile's word 0 is written to even address 32.
REQ-031 SHALL cover wrap: 32 consecutive tiles (ADDR_W = 10) -> tile 31 writes addresses 992..1023; tile 32 word 0 is written to even address 0.
REQ-032 SHALL cover back-pressure: mem_busy = 1 over the cycles of beats 5-7 -> no strobes in those cycles; beat 5 later lands at odd address 2; no word is lost or duplicated.
REQ-033 SHALL cover sync_clr: assert after word 40 is accepted, coinciding with word 41 -> word 41 is not written; next cycle has all outputs 0 and tile_base = 0; the next tile's word 0 goes to even address 0.
REQ-034 SHALL cover parity with DATA_WR_CTRL_PARITY_EN defined: in_data = 16'h0007 -> mem_wpar = 1; in_data = 16'h0003 -> mem_wpar = 0.
